mux_pattern_gen: RTL

//  Upstream stimulus stage for the 4:1 selector mux. Drives select pair a,b and

---
 rtl/mux_pattern_gen.sv | 98 +++++++++
 1 files changed

// File: rtl/mux_pattern_gen.sv
// Stimulus generator for the 4:1 selector mux: walks the 64 {a,b,A,B,C,D}
// combinations from a 6-bit pattern index under start/stop/step control.
module mux_pattern_gen #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              loop,
  input  logic [HOLD_W-1:0] hold_len,
  output logic              a,
  output logic              b,
  output logic              A,
  output logic              B,
  output logic              C,
  output logic              D,
  output logic [5:0]        pattern_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

  logic [0:0]        state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    hcnt_d  = hcnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // stop outranks start and step, so start+stop leaves everything as is
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_RUN;
          idx_d   = 6'd0;
          hold_d  = hold_len;
          hcnt_d  = '0;
        end else if (step) begin
          idx_d = idx_q + 6'd1;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (hcnt_q == hold_q) begin
          hcnt_d = '0;
          if (idx_q != 6'd63) begin
            idx_d = idx_q + 6'd1;
          end else if (loop) begin
            idx_d = 6'd0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + HOLD_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 6'd0;
      hold_q  <= '0;
      hcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
      done_q  <= done_d;
    end
  end

  // Mux ports come straight off the index register; no combinational path.
  assign {a, b, A, B, C, D} = idx_q;
  assign pattern_idx        = idx_q;
  assign busy               = (state_q == S_RUN);
  assign done               = done_q;

endmodule
